rom_word_serializer: RTL

- Sits directly upstream of the arcade core's ioctl ROM-load port, on the core clock, after the bridge CDC.
- Accepts 32-bit word writes from the bridge and buffers them in a small FIFO.
- Replays each word as four byte writes, most significant byte first, spaced so the core's loaders never see strobes closer together than CYCLES clocks.
- Reports backpressure, busy and a sticky overflow flag.

---
 rtl/rom_word_serializer.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/rom_word_serializer.sv
// rom_word_serializer: buffers 32-bit ROM words in a small FIFO and replays
// each one as four byte writes (MSB first) spaced CYCLES clocks apart.
module rom_word_serializer #(
  parameter int unsigned CYCLES     = 8,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned ADDR_WIDTH = 25
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [31:0]           in_addr,
  input  logic [31:0]           in_data,
  input  logic                  in_wr,
  output logic                  in_ready,
  output logic [ADDR_WIDTH-1:0] out_addr,
  output logic [7:0]            out_data,
  output logic                  out_wr,
  output logic                  busy,
  output logic                  overflow
);

  localparam int unsigned PW  = $clog2(FIFO_DEPTH);
  localparam int unsigned WAW = ADDR_WIDTH - 2;
  localparam int unsigned EW  = WAW + 32;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EMIT = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;

  localparam logic [7:0] CNT_LOAD = 8'(CYCLES - 1);

  // FIFO storage; entries are {word_addr, data}
  logic [EW-1:0] mem [FIFO_DEPTH];
  logic [PW:0]   wr_ptr, rd_ptr;
  logic          empty, full, push, pop;
  logic [EW-1:0] head;

  logic [1:0]            state_q, state_d;
  logic [1:0]            idx_q, idx_d;
  logic [7:0]            cnt_q, cnt_d;
  logic [EW-1:0]         word_q, word_d;
  logic                  emit;
  logic [EW-1:0]         emit_word;
  logic [1:0]            emit_idx;
  logic [ADDR_WIDTH-1:0] out_addr_q;
  logic [7:0]            out_data_q;
  logic                  out_wr_q;
  logic                  overflow_q;

  // Address bits outside the core's space and the byte offset are not used
  logic unused_addr;
  assign unused_addr = ^{in_addr[31:ADDR_WIDTH], in_addr[1:0]};

  // Extra pointer bit separates full from empty when the indices match
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign push     = in_wr && !full;
  assign head     = mem[rd_ptr[PW-1:0]];
  assign in_ready = !full;
  assign busy     = !empty || (state_q != ST_IDLE);
  assign out_addr = out_addr_q;
  assign out_data = out_data_q;
  assign out_wr   = out_wr_q;
  assign overflow = overflow_q;

  function automatic logic [7:0] sel_byte(input logic [31:0] w, input logic [1:0] i);
    logic [7:0] b;
    unique case (i)
      2'd0:    b = w[31:24];
      2'd1:    b = w[23:16];
      2'd2:    b = w[15:8];
      default: b = w[7:0];
    endcase
    return b;
  endfunction

  // FIFO write port; storage needs no reset since pointers define validity
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[PW-1:0]] <= {in_addr[ADDR_WIDTH-1:2], in_data};
  end

  // Next-state logic: the byte to emit is chosen on the transition into EMIT
  // so the outputs can be registered and appear in the EMIT cycle itself
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    word_d    = word_q;
    pop       = 1'b0;
    emit      = 1'b0;
    emit_word = word_q;
    emit_idx  = idx_q;
    unique case (state_q)
      ST_IDLE: begin
        if (!empty) begin
          pop       = 1'b1;
          word_d    = head;
          idx_d     = 2'd0;
          emit      = 1'b1;
          emit_word = head;
          emit_idx  = 2'd0;
          state_d   = ST_EMIT;
        end
      end
      ST_EMIT: begin
        cnt_d   = CNT_LOAD;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        cnt_d = cnt_q - 8'd1;
        if (cnt_q == 8'd1) begin
          if (idx_q != 2'd3) begin
            idx_d    = idx_q + 2'd1;
            emit     = 1'b1;
            emit_idx = idx_q + 2'd1;
            state_d  = ST_EMIT;
          end else if (!empty) begin
            // Prefetch keeps the cross-word gap at exactly CYCLES
            pop       = 1'b1;
            word_d    = head;
            idx_d     = 2'd0;
            emit      = 1'b1;
            emit_word = head;
            emit_idx  = 2'd0;
            state_d   = ST_EMIT;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, FIFO pointers and registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      state_q    <= ST_IDLE;
      idx_q      <= 2'd0;
      cnt_q      <= 8'd0;
      word_q     <= '0;
      out_addr_q <= '0;
      out_data_q <= 8'd0;
      out_wr_q   <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (in_wr && full) overflow_q <= 1'b1;
      state_q  <= state_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      word_q   <= word_d;
      out_wr_q <= emit;
      if (emit) begin
        // Truncation to ADDR_WIDTH gives the silent wrap at the top
        out_addr_q <= {emit_word[EW-1:32], 2'b00} + ADDR_WIDTH'(emit_idx);
        out_data_q <= sel_byte(emit_word[31:0], emit_idx);
      end
    end
  end

endmodule
